fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a prefetch buffer. It replaces the single fetch→decode pipeline register with a DEPTH-entry queue. The queue runs ahead of decode, absorbs decode stalls without stopping instruction fetch, and flushes on a branch or jump redirect. It sits between the instruction memory and the decode stage of the pipelined core.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch buffer between instruction memory and the decode stage.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (forward instrF straight to decode when the queue is empty).
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_en,
  output logic [WIDTH-1:0]           pcF,
  input  logic [WIDTH-1:0]           instrF,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       validD,
  input  logic                       stallD,
  output logic [WIDTH-1:0]           instrD,
  output logic [WIDTH-1:0]           pcD,
  output logic [WIDTH-1:0]           pcplus4D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic head_valid;
  logic full;
  logic fetch;
  logic bypass_hit;
  logic deq;
  logic deq_mem;
  logic enq;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));

  // A full queue always has a valid head, so "deq" collapses to ~stallD here;
  // this keeps fetch independent of validD and avoids a combinational loop.
  assign fetch = reset & ~redirect & (~full | ~stallD);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = fetch & ~head_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign validD  = reset & ~redirect & (head_valid | bypass_hit);
  assign deq     = validD & ~stallD;
  assign deq_mem = deq & head_valid;
  // A bypassed word taken by decode this cycle never enters storage.
  assign enq     = fetch & ~(bypass_hit & ~stallD);

  assign imem_en = fetch;
  assign pcF     = pc_q;
  assign count   = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign instrD = bypass_hit ? instrF : instr_mem[rd_ptr_q];
  assign pcD    = bypass_hit ? pc_q   : pc_mem[rd_ptr_q];
`else
  assign instrD = instr_mem[rd_ptr_q];
  assign pcD    = pc_mem[rd_ptr_q];
`endif
  assign pcplus4D = pcD + WIDTH'(4);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (fetch)   pc_d     = pc_q + WIDTH'(4);
      if (enq)     wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_mem) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= instrF;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus a randomized run against a queue-based model.
// Honours FETCH_QUEUE_BYPASS_EN so the same bench covers both builds.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              imem_en;
  logic [WIDTH-1:0]  pcF;
  logic [WIDTH-1:0]  instrF;
  logic              redirect = 1'b0;
  logic [WIDTH-1:0]  redirect_pc = '0;
  logic              validD;
  logic              stallD = 1'b0;
  logic [WIDTH-1:0]  instrD;
  logic [WIDTH-1:0]  pcD;
  logic [WIDTH-1:0]  pcplus4D;
  logic [2:0]        count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .pcF(pcF), .instrF(instrF),
    .redirect(redirect), .redirect_pc(redirect_pc), .validD(validD), .stallD(stallD),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at address 4k holds k.
  always_comb instrF = pcF >> 2;

  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc, input logic stall);
    @(negedge clk);
    reset = rst; redirect = redir; redirect_pc = rpc; stallD = stall;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
    n_cmp++; if (validD !== 1'b0) begin n_err++; $display("FAIL reset_validD: got %b expected 0", validD); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (pcF !== 32'h0) begin n_err++; $display("FAIL reset_pcF: got %h expected 0", pcF); end
    $display("test_reset: done");
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n_cmp++; if (imem_en !== 1'b1) begin n_err++; $display("FAIL stream_imem_en c%0d: got %b expected 1", c, imem_en); end
      n_cmp++; if (pcF !== 32'(4*c)) begin n_err++; $display("FAIL stream_pcF c%0d: got %h expected %h", c, pcF, 32'(4*c)); end
      n_cmp++; if (count !== ((c == 0) ? 3'd0 : 3'(LAT))) begin n_err++; $display("FAIL stream_count c%0d: got %0d expected %0d", c, count, (c == 0) ? 0 : LAT); end
      n_cmp++; if (validD !== (c >= LAT)) begin n_err++; $display("FAIL stream_validD c%0d: got %b expected %b", c, validD, c >= LAT); end
      if (c >= LAT) begin
        n_cmp++; if (pcD !== 32'(4*(c-LAT))) begin n_err++; $display("FAIL stream_pcD c%0d: got %h expected %h", c, pcD, 32'(4*(c-LAT))); end
        n_cmp++; if (instrD !== 32'(c-LAT)) begin n_err++; $display("FAIL stream_instrD c%0d: got %h expected %h", c, instrD, 32'(c-LAT)); end
        n_cmp++; if (pcplus4D !== 32'(4*(c-LAT)+4)) begin n_err++; $display("FAIL stream_pcplus4D c%0d: got %h expected %h", c, pcplus4D, 32'(4*(c-LAT)+4)); end
      end
      $display("test_stream c%0d: pcF=%h validD=%b pcD=%h count=%0d", c, pcF, validD, pcD, count);
    end
  endtask

  task automatic test_full();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++; if (count !== 3'((c > 4) ? 4 : c)) begin n_err++; $display("FAIL full_count c%0d: got %0d expected %0d", c, count, (c > 4) ? 4 : c); end
      if (c >= 4) begin
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL full_imem_en c%0d: got %b expected 0", c, imem_en); end
        n_cmp++; if (pcF !== 32'h10) begin n_err++; $display("FAIL full_pcF c%0d: got %h expected 10", c, pcF); end
        n_cmp++; if (validD !== 1'b1 || pcD !== 32'h0) begin n_err++; $display("FAIL full_head c%0d: got valid=%b pcD=%h expected valid=1 pcD=0", c, validD, pcD); end
      end else begin
        n_cmp++; if (imem_en !== 1'b1 || pcF !== 32'(4*c)) begin n_err++; $display("FAIL full_fill c%0d: got en=%b pcF=%h expected en=1 pcF=%h", c, imem_en, pcF, 32'(4*c)); end
      end
      $display("test_full c%0d: count=%0d imem_en=%b pcF=%h", c, count, imem_en, pcF);
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n_cmp++; if (imem_en !== 1'b1 || validD !== 1'b1) begin n_err++; $display("FAIL full_release c%0d: got en=%b valid=%b expected 1 1", c, imem_en, validD); end
      n_cmp++; if (pcD !== 32'(4*c) || count !== 3'd4) begin n_err++; $display("FAIL full_release_data c%0d: got pcD=%h count=%0d expected pcD=%h count=4", c, pcD, count, 32'(4*c)); end
      n_cmp++; if (pcF !== 32'(16+4*c)) begin n_err++; $display("FAIL full_release_pcF c%0d: got %h expected %h", c, pcF, 32'(16+4*c)); end
      $display("test_full release c%0d: pcD=%h count=%0d", c, pcD, count);
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
    n_cmp++; if (imem_en !== 1'b0 || validD !== 1'b0) begin n_err++; $display("FAIL redir_cycle: got en=%b valid=%b expected 0 0", imem_en, validD); end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (count !== 3'd0 || pcF !== 32'h100) begin n_err++; $display("FAIL redir_next: got count=%0d pcF=%h expected 0 100", count, pcF); end
    n_cmp++; if (validD !== BYP || imem_en !== 1'b1) begin n_err++; $display("FAIL redir_next_valid: got valid=%b en=%b expected %b 1", validD, imem_en, BYP); end
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_cmp++; if (validD !== 1'b1 || pcD !== (BYP ? 32'h104 : 32'h100)) begin n_err++; $display("FAIL redir_target: got valid=%b pcD=%h expected 1 %h", validD, pcD, BYP ? 32'h104 : 32'h100); end
    n_cmp++; if (instrD !== (BYP ? 32'h41 : 32'h40)) begin n_err++; $display("FAIL redir_instrD: got %h expected %h", instrD, BYP ? 32'h41 : 32'h40); end
    $display("test_redirect: pcD=%h instrD=%h", pcD, instrD);
  endtask

  task automatic test_redirect_stall();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 32'h200, 1'b1);
    n_cmp++; if (count !== 3'd4 || imem_en !== 1'b0 || validD !== 1'b0) begin n_err++; $display("FAIL rstall_cycle: got count=%0d en=%b valid=%b expected 4 0 0", count, imem_en, validD); end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (count !== 3'd0 || pcF !== 32'h200 || imem_en !== 1'b1) begin n_err++; $display("FAIL rstall_flush: got count=%0d pcF=%h en=%b expected 0 200 1", count, pcF, imem_en); end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (count !== 3'd1 || validD !== 1'b1 || pcD !== 32'h200 || pcF !== 32'h204) begin n_err++; $display("FAIL rstall_target: got count=%0d valid=%b pcD=%h pcF=%h expected 1 1 200 204", count, validD, pcD, pcF); end
    $display("test_redirect_stall: pcD=%h count=%0d", pcD, count);
  endtask

  task automatic test_reset_midrun();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h38, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (count !== 3'd2 || pcF !== 32'h40) begin n_err++; $display("FAIL mid_pre: got count=%0d pcF=%h expected 2 40", count, pcF); end
    n_cmp++; if (imem_en !== 1'b0 || validD !== 1'b0) begin n_err++; $display("FAIL mid_held: got en=%b valid=%b expected 0 0", imem_en, validD); end
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (count !== 3'd0 || pcF !== 32'h0 || validD !== BYP || imem_en !== 1'b1) begin n_err++; $display("FAIL mid_after: got count=%0d pcF=%h valid=%b en=%b expected 0 0 %b 1", count, pcF, validD, imem_en, BYP); end
    $display("test_reset_midrun: count=%0d pcF=%h", count, pcF);
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    logic [31:0] m_pc;
    logic        rst, redir, stall, e_en, e_valid, consumed;
    logic [31:0] rpc, e_pc, e_ins;
    int          stall_pct;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    q.delete();
    m_pc = 32'h0;
    stall_pct = 30;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) stall_pct = (i % 150 == 0) ? 10 : ((i % 150 == 50) ? 50 : 90);
      rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      redir = ($urandom_range(0, 11) == 0);
      rpc   = $urandom();
      stall = ($urandom_range(0, 99) < stall_pct);
      drive(rst, redir, rpc, stall);
      if (!rst || redir) begin
        e_en = 1'b0; e_valid = 1'b0;
      end else begin
        e_en    = (q.size() < DEPTH) || (q.size() > 0 && !stall);
        e_valid = (q.size() > 0) || (BYP && e_en);
      end
      if (q.size() > 0) begin e_pc = q[0].pc; e_ins = q[0].ins; end
      else begin e_pc = m_pc; e_ins = m_pc >> 2; end
      n_cmp++; if (imem_en !== e_en) begin n_err++; $display("FAIL rnd_imem_en i%0d: got %b expected %b", i, imem_en, e_en); end
      n_cmp++; if (validD !== e_valid) begin n_err++; $display("FAIL rnd_validD i%0d: got %b expected %b", i, validD, e_valid); end
      n_cmp++; if (count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count i%0d: got %0d expected %0d", i, count, q.size()); end
      n_cmp++; if (pcF !== m_pc) begin n_err++; $display("FAIL rnd_pcF i%0d: got %h expected %h", i, pcF, m_pc); end
      if (e_valid) begin
        n_cmp++; if (pcD !== e_pc) begin n_err++; $display("FAIL rnd_pcD i%0d: got %h expected %h", i, pcD, e_pc); end
        n_cmp++; if (instrD !== e_ins) begin n_err++; $display("FAIL rnd_instrD i%0d: got %h expected %h", i, instrD, e_ins); end
        n_cmp++; if (pcplus4D !== e_pc + 32'd4) begin n_err++; $display("FAIL rnd_pcplus4D i%0d: got %h expected %h", i, pcplus4D, e_pc + 32'd4); end
      end
      $display("rnd i%0d: rst=%b redir=%b stall=%b en=%b valid=%b pcD=%h count=%0d", i, rst, redir, stall, imem_en, validD, pcD, count);
      if (!rst) begin
        q.delete(); m_pc = 32'h0;
      end else if (redir) begin
        q.delete(); m_pc = rpc;
      end else begin
        consumed = 1'b0;
        if (e_valid && !stall) begin
          if (q.size() > 0) void'(q.pop_front());
          else consumed = 1'b1;
        end
        if (e_en) begin
          if (!consumed) q.push_back('{pc: m_pc, ins: m_pc >> 2});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_stall();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
